// File: rtl/cache_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_arbiter_if
// Bundles the three buses around the cache arbiter:
//   icache side : i_pmem_read, i_pmem_address  -> arbiter
//                 i_pmem_rdata, i_pmem_resp    <- arbiter
//   dcache side : d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata -> arbiter
//                 d_pmem_rdata, d_pmem_resp    <- arbiter
//   memory side : pmem_read, pmem_write, pmem_address, pmem_wdata <- arbiter
//                 pmem_rdata, pmem_resp        -> arbiter
// Modports:
//   slave  - the arbiter's view (consumes requests, produces strobes/resp)
//   master - the environment's view (caches and physical memory)
// ---------------------------------------------------------------------------
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // icache miss path
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    // dcache miss / writeback path
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    // physical memory port
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Shares the single physical-memory port between the icache line-fill path
// and the dcache line-fill/writeback path. One line transfer is in flight at
// a time; simultaneous requests are resolved round-robin so neither cache
// can starve the other.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset; abandons any in-flight transfer
//   bus   - cache_arbiter_if.slave carrying the icache, dcache and memory buses
// Each transfer is: grant cycle (IDLE) -> SERVE_x until pmem_resp ->
// one RELEASE cycle that lets the finished cache drop its request.
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic            clk,
    input logic            rst_n,
    cache_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    op_e               op_q, op_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;

    logic i_req;
    logic d_req;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;

        case (state_q)
            IDLE: begin
                // icache wins when alone, or on a tie when dcache had the last grant.
                if (i_req && (!d_req || last_grant_q)) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                    addr_d       = bus.i_pmem_address;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                end else if (d_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                    addr_d       = bus.d_pmem_address;
                    wdata_d      = bus.d_pmem_wdata;
                    // Write dominates if the dcache ever raises both strobes.
                    op_d         = bus.d_pmem_write ? OP_WRITE : OP_READ;
                    pmem_read_d  = ~bus.d_pmem_write;
                    pmem_write_d = bus.d_pmem_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d      = RELEASE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            RELEASE: begin
                // Requests are deliberately ignored here: the cache that just
                // finished may still show its (stale) request for this cycle.
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: the line-wide wdata register is reset too, so memory never sees stale data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= OP_READ;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    // Memory side is driven purely from the latched copies.
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // Read data is a plain fan-out; only the resp pulse selects the owner.
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
    assign bus.i_pmem_resp  = (state_q == SERVE_I) & bus.pmem_resp;
    assign bus.d_pmem_resp  = (state_q == SERVE_D) & bus.pmem_resp;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Arbitrates the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Sits below both caches and above physical memory.
- Serialises line transfers: exactly one requester owns memory at a time.
- Tie-break is round-robin, so neither cache can starve the other. This keeps the icache_stall/dcache_stall signals seen by hazard detection bounded.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  icache line-fill request, held until i_pmem_resp
i_pmem_address  in  ADDR_W  icache line address, stable while requesting
i_pmem_rdata  out  LINE_W  fill data to icache
i_pmem_resp  out  1  icache transfer complete, one-cycle pulse
d_pmem_read  in  1  dcache line-fill request
d_pmem_write  in  1  dcache writeback request; never asserted together with d_pmem_read
d_pmem_address  in  ADDR_W  dcache line address
d_pmem_wdata  in  LINE_W  dcache writeback data
d_pmem_rdata  out  LINE_W  fill data to dcache
d_pmem_resp  out  1  dcache transfer complete, one-cycle pulse
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
pmem_resp  in  1  memory transfer complete

Behaviour:
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
  - RELEASE
- Registers:
  - state
  - last_grant (0 = icache, 1 = dcache)
  - addr_q
  - wdata_q
  - op_q (read/write)
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = 0, addr_q = 0, wdata_q = 0, op_q = read.
  - All outputs 0.
  - Any in-flight memory transaction is abandoned; no resp is issued to either cache.
- IDLE, request handling:
  - i_req = i_pmem_read.
  - d_req = d_pmem_read | d_pmem_write.
  - Only i_req: grant icache.
  - Only d_req: grant dcache.
  - Both: grant the requester not in last_grant. First tie after reset goes to dcache.
- Grant action (on the same clock edge):
  - Latch the winner's address into addr_q.
  - For dcache, also latch wdata into wdata_q and the op into op_q.
  - Update last_grant.
  - Move to SERVE_I or SERVE_D.
- Grant latency: request visible in cycle N means pmem strobe asserted in cycle N+1.
- SERVE_x:
  - pmem_address = addr_q and pmem_wdata = wdata_q.
  - pmem_read = 1 for SERVE_I, or for SERVE_D with op_q = read.
  - pmem_write = 1 for SERVE_D with op_q = write.
  - Strobes stay high until pmem_resp.
- Completion (cycle with pmem_resp = 1 in SERVE_x):
  - x_pmem_resp = 1 combinationally for that cycle only.
  - x_pmem_rdata = pmem_rdata, passed through.
  - The other cache's resp stays 0.
  - Next state is RELEASE.
- RELEASE:
  - Lasts one cycle; strobes 0, all resp 0, requests ignored.
  - Gives the finishing cache one cycle to drop its request, so a stale request is never re-granted.
  - Then IDLE.
- i_pmem_rdata and d_pmem_rdata may mirror pmem_rdata at all times. Only the resp pulse is qualified.
- Minimum occupancy per transfer is grant cycle + memory latency + RELEASE. Back-to-back transfers: a losing requester is granted in the IDLE cycle right after RELEASE.
- Boundary cases:
  - Requester inputs changing mid-transfer have no effect, since latched copies drive memory.
  - pmem_resp in IDLE or RELEASE is ignored.
  - d_pmem_read and d_pmem_write both high is illegal; write takes precedence in op_q.
  - rst_n asserted mid-SERVE: strobes drop asynchronously.

Test Plan:
- Reset then idle: rst_n low with i_pmem_read = 1 → all outputs 0. After release with memory latency 3, i_pmem_read = 1, i_pmem_address = 0x0000_0060 → pmem_read high from the next cycle with pmem_address 0x60. i_pmem_resp pulses once, in the cycle pmem_resp = 1, with i_pmem_rdata equal to the memory line.
- Simultaneous fresh requests: i_pmem_read = 1 and d_pmem_read = 1 in the same cycle after reset → dcache served first (address 0x0000_1000), RELEASE, then icache served. No cycle has both strobes high.
- Round-robin: both caches hold requests continuously for four transfers → grant order D, I, D, I. Each resp pulse is exactly one cycle.
- Writeback: d_pmem_write = 1, address 0x0000_2040, wdata = {8{32'hDEAD_BEEF}}; d_pmem_wdata changed to 0 one cycle after grant → pmem_write high, pmem_wdata still DEAD_BEEF pattern, pmem_read stays 0, d_pmem_resp pulses on pmem_resp.
- Stale request: dcache keeps d_pmem_read high one extra cycle after its resp → no second grant to dcache during RELEASE. A pending icache request is granted next.
- Reset mid-transfer: rst_n pulsed low while in SERVE_I, 2 cycles before pmem_resp → pmem_read drops immediately and i_pmem_resp never pulses. After release the FSM returns to IDLE and the first tie goes to dcache again.
